ibex_rf_wb_buffer: RTL and testbench

//  Write-back staging buffer between the WB stage and the register file write port.

---
 rtl/ibex_rf_wb_pkg.sv | 17 +
 rtl/ibex_rf_wb_match.sv | 37 +++
 rtl/ibex_rf_wb_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_ibex_rf_wb_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_wb_pkg.sv
// ibex_rf_wb_pkg
//   Shared types and constants for the register-file write-back buffer.
//   wb_entry_t : one buffered write (valid flag, destination register, data)
//   RegAddrW   : register address width
//   DataW      : register data width held in an entry
package ibex_rf_wb_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 32;

  typedef struct packed {
    logic                valid;
    logic [RegAddrW-1:0] addr;
    logic [DataW-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/ibex_rf_wb_match.sv
// ibex_rf_wb_match
//   Combinational address lookup over the buffer entries.
//   entries_i : buffer contents
//   mask_i    : per-entry enable; masked entries never hit
//   addr_i    : register address to look up (x0 never hits)
//   hit_oh_o  : one-hot hit vector
//   hit_o     : any entry hit
//   data_o    : data of the hitting entry, zero on miss
module ibex_rf_wb_match
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  wb_entry_t           entries_i [Depth],
  input  logic [Depth-1:0]    mask_i,
  input  logic [RegAddrW-1:0] addr_i,
  output logic [Depth-1:0]    hit_oh_o,
  output logic                hit_o,
  output logic [DataW-1:0]    data_o
);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    hit_oh_o = '0;
    data_o   = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      hit_oh_o[i] = mask_i[i] & entries_i[i].valid &
                    (entries_i[i].addr == addr_i) & (addr_i != '0);
      // At most one entry per address exists, so an OR-mux is exact.
      if (hit_oh_o[i]) data_o = data_o | entries_i[i].data;
    end
  end

  assign hit_o = |hit_oh_o;

endmodule

// File: rtl/ibex_rf_wb_buffer.sv
// ibex_rf_wb_buffer
//   Write-back staging buffer between WB and the register-file write port.
//   Queues results in order, coalesces repeat writes to one register in place,
//   and forwards pending data to both ID read ports.
//   WB side : wb_valid_i/wb_addr_i/wb_data_i in, wb_ready_o out
//   RF side : rf_we_o/rf_waddr_o/rf_wdata_o out, rf_ready_i in
//   Reads   : raddr_{a,b}_i in, fwd_{a,b}_valid_o/fwd_{a,b}_data_o out
//   Status  : empty_o, full_o, wr_count_o (RF writes), coalesce_cnt_o
module ibex_rf_wb_buffer
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wb_valid_i,
  input  logic [RegAddrW-1:0]  wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  output logic                 wb_ready_o,
  output logic                 rf_we_o,
  output logic [RegAddrW-1:0]  rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic                 rf_ready_i,
  input  logic [RegAddrW-1:0]  raddr_a_i,
  output logic                 fwd_a_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  input  logic [RegAddrW-1:0]  raddr_b_i,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [CntWidth-1:0]  wr_count_o,
  output logic [CntWidth-1:0]  coalesce_cnt_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;

  wb_entry_t          entries_q [Depth];
  wb_entry_t          head;
  logic [PtrW-1:0]    head_q, tail_q;
  logic [CountW-1:0]  count_q, count_d;
  logic               empty_q, full_q;
  logic [CntWidth-1:0] wr_cnt_q, coal_cnt_q;

  logic               pop, push, addr_zero, do_coal, do_alloc;
  logic [Depth-1:0]   coal_mask, coal_oh;
  logic               coal_hit;
  logic [DataW-1:0]   coal_data_unused;
  logic [Depth-1:0]   a_oh_unused, b_oh_unused;
  logic               a_hit, b_hit;
  logic [DataW-1:0]   a_data, b_data;

  // ---------------------------------------------------------------------------
  // RF side: head entry drives the write port directly (no WB->RF bypass).
  // ---------------------------------------------------------------------------
  assign head       = entries_q[head_q];
  assign rf_we_o    = head.valid;
  assign rf_waddr_o = head.addr;
  assign rf_wdata_o = head.data;
  assign pop        = rf_we_o & rf_ready_i;

  // ---------------------------------------------------------------------------
  // Coalesce lookup. The head is excluded while it is being popped: its write
  // is already committed, so a same-address push must queue behind it. A head
  // not popped this cycle may still be rewritten in place.
  // ---------------------------------------------------------------------------
  always_comb begin
    coal_mask = '1;
    if (pop) coal_mask[head_q] = 1'b0;
  end

  ibex_rf_wb_match #(.Depth(Depth)) u_coal_match (
    .entries_i (entries_q),
    .mask_i    (coal_mask),
    .addr_i    (wb_addr_i),
    .hit_oh_o  (coal_oh),
    .hit_o     (coal_hit),
    .data_o    (coal_data_unused)
  );

  assign addr_zero  = (wb_addr_i == '0);
  // x0 writes are always taken and dropped; a pop frees a slot this cycle.
  assign wb_ready_o = ~full_q | coal_hit | pop | addr_zero;
  assign push       = wb_valid_i & wb_ready_o;
  assign do_coal    = push & ~addr_zero & coal_hit;
  assign do_alloc   = push & ~addr_zero & ~coal_hit;

  always_comb begin
    count_d = count_q;
    case ({do_alloc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Forwarding: an incoming push beats the buffered copy of the same register.
  // ---------------------------------------------------------------------------
  ibex_rf_wb_match #(.Depth(Depth)) u_fwd_a_match (
    .entries_i (entries_q),
    .mask_i    ({Depth{1'b1}}),
    .addr_i    (raddr_a_i),
    .hit_oh_o  (a_oh_unused),
    .hit_o     (a_hit),
    .data_o    (a_data)
  );

  ibex_rf_wb_match #(.Depth(Depth)) u_fwd_b_match (
    .entries_i (entries_q),
    .mask_i    ({Depth{1'b1}}),
    .addr_i    (raddr_b_i),
    .hit_oh_o  (b_oh_unused),
    .hit_o     (b_hit),
    .data_o    (b_data)
  );

  always_comb begin
    fwd_a_valid_o = 1'b0;
    fwd_a_data_o  = '0;
    if (raddr_a_i != '0) begin
      if (push && (wb_addr_i == raddr_a_i)) begin
        fwd_a_valid_o = 1'b1;
        fwd_a_data_o  = wb_data_i;
      end else if (a_hit) begin
        fwd_a_valid_o = 1'b1;
        fwd_a_data_o  = a_data;
      end
    end
  end

  always_comb begin
    fwd_b_valid_o = 1'b0;
    fwd_b_data_o  = '0;
    if (raddr_b_i != '0) begin
      if (push && (wb_addr_i == raddr_b_i)) begin
        fwd_b_valid_o = 1'b1;
        fwd_b_data_o  = wb_data_i;
      end else if (b_hit) begin
        fwd_b_valid_o = 1'b1;
        fwd_b_data_o  = b_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: the entry array is tiny, so it is reset in full (data too); this keeps
  // rf_wdata_o defined out of reset and makes reset discard pending writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) entries_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      wr_cnt_q   <= '0;
      coal_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking updates, last one wins. When full, push+pop targets
      // the same slot (tail == head); the allocate below must override the
      // pop's valid clear, so it is written after it.
      if (pop) begin
        entries_q[head_q].valid <= 1'b0;
        head_q                  <= head_q + 1'b1;
      end
      if (do_coal) begin
        for (int i = 0; i < int'(Depth); i++) begin
          if (coal_oh[i]) entries_q[i].data <= wb_data_i;
        end
      end
      if (do_alloc) begin
        entries_q[tail_q] <= '{valid: 1'b1, addr: wb_addr_i, data: wb_data_i};
        tail_q            <= tail_q + 1'b1;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CountW'(Depth));
      if (pop && !(&wr_cnt_q))       wr_cnt_q   <= wr_cnt_q + 1'b1;
      if (do_coal && !(&coal_cnt_q)) coal_cnt_q <= coal_cnt_q + 1'b1;
    end
  end

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign wr_count_o     = wr_cnt_q;
  assign coalesce_cnt_o = coal_cnt_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  logic dup_addr;
  always_comb begin
    dup_addr = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      for (int j = i + 1; j < int'(Depth); j++) begin
        if (entries_q[i].valid && entries_q[j].valid &&
            (entries_q[i].addr == entries_q[j].addr)) begin
          dup_addr = 1'b1;
        end
      end
    end
  end

  a_unique_addr: assert property (@(posedge clk_i) disable iff (!rst_ni) !dup_addr);
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  count_q <= CountW'(Depth));
  a_head_valid:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  rf_we_o == (count_q != '0));

endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// tb_ibex_rf_wb_buffer
//   Directed self-checking bench for ibex_rf_wb_buffer. Inputs change 1 ns
//   after the rising edge; outputs are compared once they have settled.
module tb_ibex_rf_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_ready_i;
  logic [4:0]  raddr_a_i, raddr_b_i;
  logic        fwd_a_valid_o, fwd_b_valid_o;
  logic [31:0] fwd_a_data_o, fwd_b_data_o;
  logic        empty_o, full_o;
  logic [31:0] wr_count_o, coalesce_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  ibex_rf_wb_buffer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wb_valid_i     (wb_valid_i),
    .wb_addr_i      (wb_addr_i),
    .wb_data_i      (wb_data_i),
    .wb_ready_o     (wb_ready_o),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .rf_ready_i     (rf_ready_i),
    .raddr_a_i      (raddr_a_i),
    .fwd_a_valid_o  (fwd_a_valid_o),
    .fwd_a_data_o   (fwd_a_data_o),
    .raddr_b_i      (raddr_b_i),
    .fwd_b_valid_o  (fwd_b_valid_o),
    .fwd_b_data_o   (fwd_b_data_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .wr_count_o     (wr_count_o),
    .coalesce_cnt_o (coalesce_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid_i = v;
    wb_addr_i  = a;
    wb_data_i  = d;
    #1;
  endtask

  task automatic rf_rdy(input logic r);
    rf_ready_i = r;
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    raddr_a_i = a;
    raddr_b_i = b;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    rf_ready_i = 1'b0; raddr_a_i = '0; raddr_b_i = '0;
    #12;
    check("rst_rf_we",    32'(rf_we_o),       32'd0);
    check("rst_empty",    32'(empty_o),       32'd1);
    check("rst_full",     32'(full_o),        32'd0);
    check("rst_wb_ready", 32'(wb_ready_o),    32'd1);
    check("rst_fwd_a_v",  32'(fwd_a_valid_o), 32'd0);
    check("rst_fwd_b_d",  fwd_b_data_o,       32'd0);
    check("rst_wr_cnt",   wr_count_o,         32'd0);
    check("rst_coal_cnt", coalesce_cnt_o,     32'd0);
    rst_ni = 1'b1;
    step();

    // In-order drain with the RF always ready.
    rf_rdy(1'b1);
    wb(1'b1, 5'd5, 32'h11);
    check("t1_ready", 32'(wb_ready_o), 32'd1);
    check("t1_no_bypass", 32'(rf_we_o), 32'd0);
    step();
    wb(1'b1, 5'd6, 32'h22);
    check("t1_we_c2",    32'(rf_we_o),    32'd1);
    check("t1_addr_c2",  32'(rf_waddr_o), 32'd5);
    check("t1_data_c2",  rf_wdata_o,      32'h11);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("t1_addr_c3",  32'(rf_waddr_o), 32'd6);
    check("t1_data_c3",  rf_wdata_o,      32'h22);
    check("t1_wr_c3",    wr_count_o,      32'd1);
    step();
    check("t1_we_done",  32'(rf_we_o),    32'd0);
    check("t1_wr_cnt",   wr_count_o,      32'd2);
    check("t1_empty",    32'(empty_o),    32'd1);

    // Fill with RF stalled, then push+pop while full.
    rf_rdy(1'b0);
    for (int i = 1; i <= 4; i++) begin
      wb(1'b1, 5'(i), 32'h100 + 32'(i));
      step();
    end
    wb(1'b1, 5'd7, 32'h77);
    check("t2_full",       32'(full_o),     32'd1);
    check("t2_ready_full", 32'(wb_ready_o), 32'd0);
    check("t2_head_hold",  32'(rf_waddr_o), 32'd1);
    check("t2_head_data",  rf_wdata_o,      32'h101);
    rf_rdy(1'b1);
    check("t2_ready_pop",  32'(wb_ready_o), 32'd1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    rd(5'd7, 5'd1);
    check("t2_still_full", 32'(full_o),        32'd1);
    check("t2_fwd_x7_v",   32'(fwd_a_valid_o), 32'd1);
    check("t2_fwd_x7_d",   fwd_a_data_o,       32'h77);
    check("t2_fwd_x1_v",   32'(fwd_b_valid_o), 32'd0);
    check("t2_wr_cnt",     wr_count_o,         32'd3);
    begin
      logic [4:0] order [4];
      order = '{5'd2, 5'd3, 5'd4, 5'd7};
      for (int k = 0; k < 4; k++) begin
        check("t2_drain_addr", 32'(rf_waddr_o), 32'(order[k]));
        step();
      end
    end
    check("t2_drained",  32'(empty_o),  32'd1);
    check("t2_wr_cnt_7", wr_count_o,    32'd7);
    rd(5'd0, 5'd0);

    // Coalescing into a stalled head.
    rf_rdy(1'b0);
    wb(1'b1, 5'd3, 32'hA);
    step();
    wb(1'b1, 5'd3, 32'hB);
    check("t3_ready", 32'(wb_ready_o), 32'd1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("t3_coal_cnt", coalesce_cnt_o,  32'd1);
    check("t3_addr",     32'(rf_waddr_o), 32'd3);
    check("t3_data",     rf_wdata_o,      32'hB);
    rf_rdy(1'b1);
    step();
    check("t3_one_entry", 32'(empty_o), 32'd1);
    check("t3_we_off",    32'(rf_we_o), 32'd0);
    check("t3_wr_cnt",    wr_count_o,   32'd8);

    // Forwarding from buffer and from the incoming push.
    rf_rdy(1'b0);
    wb(1'b1, 5'd9, 32'h55);
    step();
    wb(1'b0, 5'd0, 32'h0);
    rd(5'd9, 5'd9);
    check("t4_fwd_a_v", 32'(fwd_a_valid_o), 32'd1);
    check("t4_fwd_a_d", fwd_a_data_o,       32'h55);
    wb(1'b1, 5'd9, 32'h66);
    check("t4_fwd_a_push", fwd_a_data_o, 32'h66);
    check("t4_fwd_b_push", fwd_b_data_o, 32'h66);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("t4_coal_cnt",  coalesce_cnt_o, 32'd2);
    check("t4_fwd_b_buf", fwd_b_data_o,   32'h66);
    rd(5'd9, 5'd10);
    check("t4_miss_v", 32'(fwd_b_valid_o), 32'd0);
    check("t4_miss_d", fwd_b_data_o,       32'd0);
    rf_rdy(1'b1);
    step();
    check("t4_wr_cnt",   wr_count_o,         32'd9);
    check("t4_gone_v",   32'(fwd_a_valid_o), 32'd0);

    // Writes to x0 are accepted and dropped.
    rf_rdy(1'b0);
    wb(1'b1, 5'd0, 32'hFF);
    rd(5'd0, 5'd0);
    check("t5_ready",  32'(wb_ready_o),    32'd1);
    check("t5_fwd_v",  32'(fwd_a_valid_o), 32'd0);
    check("t5_fwd_d",  fwd_a_data_o,       32'd0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("t5_no_we",   32'(rf_we_o),   32'd0);
    check("t5_empty",   32'(empty_o),   32'd1);
    check("t5_coal",    coalesce_cnt_o, 32'd2);
    check("t5_wr",      wr_count_o,     32'd9);

    // Push to the head's address while it pops: a new entry, not a coalesce.
    wb(1'b1, 5'd12, 32'h1);
    step();
    rf_rdy(1'b1);
    wb(1'b1, 5'd12, 32'h2);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("t6_we",    32'(rf_we_o),    32'd1);
    check("t6_addr",  32'(rf_waddr_o), 32'd12);
    check("t6_data",  rf_wdata_o,      32'h2);
    check("t6_coal",  coalesce_cnt_o,  32'd2);
    check("t6_wr",    wr_count_o,      32'd10);
    step();
    check("t6_empty", 32'(empty_o),    32'd1);
    check("t6_wr2",   wr_count_o,      32'd11);

    // Reset while draining a full buffer.
    rf_rdy(1'b0);
    for (int i = 1; i <= 4; i++) begin
      wb(1'b1, 5'(i), 32'h200 + 32'(i));
      step();
    end
    wb(1'b0, 5'd0, 32'h0);
    check("t7_full", 32'(full_o), 32'd1);
    rf_rdy(1'b1);
    step();
    check("t7_wr_pre", wr_count_o, 32'd12);
    #2 rst_ni = 1'b0;
    #1;
    check("t7_rst_we",    32'(rf_we_o),    32'd0);
    check("t7_rst_empty", 32'(empty_o),    32'd1);
    check("t7_rst_full",  32'(full_o),     32'd0);
    check("t7_rst_wr",    wr_count_o,      32'd0);
    check("t7_rst_coal",  coalesce_cnt_o,  32'd0);
    #1 rst_ni = 1'b1;
    step();
    check("t7_post_we",    32'(rf_we_o), 32'd0);
    check("t7_post_empty", 32'(empty_o), 32'd1);
    check("t7_post_wr",    wr_count_o,   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
